// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Handshake and data bundle for the bit-serial subtractor.
//   master : drives start/a/b, observes busy/done/d/bout/ovf
//   slave  : the subtractor side
//   start  - request a subtraction (taken only while not busy)
//   a, b   - minuend / subtrahend, captured when start is taken
//   busy   - subtraction in progress
//   done   - one-cycle completion pulse
//   d      - a - b modulo 2^WIDTH, held until the next completion
//   bout   - final borrow (unsigned a < unsigned b)
//   ovf    - signed overflow
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, d, bout, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, d, bout, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor, d = a - b, LSB first, one bit
//   per clock through a single full-subtractor cell with a registered borrow.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous reset, active-high, overrides everything
//     bus  - serial_subtractor_if slave modport (start/a/b in,
//            busy/done/d/bout/ovf out)
//   Timing: start taken at edge E0, bits processed at E1..E(WIDTH),
//   done high for the cycle after E(WIDTH). A start seen during the done
//   cycle is taken immediately, giving one result per WIDTH+1 cycles.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_bw;
    logic [CW-1:0]    r_cnt;
    logic             r_amsb;
    logic             r_bmsb;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic             w_ai;
    logic             w_bi;
    logic             w_dbit;
    logic             w_bw_nxt;
    logic [WIDTH-1:0] w_diff_nxt;

    // Start is honoured in IDLE and in DONE (back-to-back), never in RUN.
    assign w_accept   = bus.start && (r_state != S_RUN);
    assign w_last     = (r_state == S_RUN) && (r_cnt == CW'(WIDTH - 1));

    // Full-subtractor cell on the current LSBs.
    assign w_ai       = r_a[0];
    assign w_bi       = r_b[0];
    assign w_dbit     = w_ai ^ w_bi ^ r_bw;
    assign w_bw_nxt   = (~w_ai & w_bi) | (~w_ai & r_bw) | (w_bi & r_bw);
    // Difference bits enter at the MSB, so after WIDTH shifts bit 0 sits at 0.
    assign w_diff_nxt = {w_dbit, r_diff[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = bus.start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_diff <= '0;
            r_bw   <= 1'b0;
            r_cnt  <= '0;
            r_amsb <= 1'b0;
            r_bmsb <= 1'b0;
            r_d    <= '0;
            r_bout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_bw   <= 1'b0;
            r_cnt  <= '0;
            r_amsb <= bus.a[WIDTH-1];
            r_bmsb <= bus.b[WIDTH-1];
        end else if (r_state == S_RUN) begin
            r_diff <= w_diff_nxt;
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_bw   <= w_bw_nxt;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                r_d    <= w_diff_nxt;
                r_bout <= w_bw_nxt;
                // Overflow only possible when operand signs differ and the
                // result sign disagrees with the minuend.
                r_ovf  <= (r_amsb != r_bmsb) && (w_diff_nxt[WIDTH-1] != r_amsb);
            end
        end
    end

    assign bus.busy = (r_state == S_RUN);
    assign bus.done = (r_state == S_DONE);
    assign bus.d    = r_d;
    assign bus.bout = r_bout;
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
    localparam int T = 10;

    logic clk = 1'b0;
    logic rst8 = 1'b1;
    logic rst2 = 1'b1;
    always #(T/2) clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(2)) if2 ();

    serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst8), .bus(if8.slave));
    serial_subtractor #(.WIDTH(2)) u2 (.clk(clk), .rst(rst2), .bus(if2.slave));

    typedef struct {
        logic [31:0] d;
        logic        bout;
        logic        ovf;
        time         tdone;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b, input time tn);
        exp_t e;
        longint ua, ub, sa, sb, sd, m;
        m  = longint'(1) << w;
        ua = longint'(a) & (m - 1);
        ub = longint'(b) & (m - 1);
        sa = (ua >= m/2) ? ua - m : ua;
        sb = (ub >= m/2) ? ub - m : ub;
        sd = sa - sb;
        e.d     = 32'((ua - ub + m) % m);
        e.bout  = (ua < ub);
        e.ovf   = (sd < -(m/2)) || (sd > (m/2 - 1));
        e.tdone = tn + time'((w + 1) * T);
        return e;
    endfunction

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (if8.done === 1'b1) begin
            if (q8.size() == 0) begin
                chk("w8 unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q8.pop_front();
                chk("w8 d", 32'(if8.d), e.d);
                chk("w8 bout", 32'(if8.bout), 32'(e.bout));
                chk("w8 ovf", 32'(if8.ovf), 32'(e.ovf));
                chk("w8 done time", 32'($time), 32'(e.tdone));
            end
        end
    end

    always @(negedge clk) begin
        if (if2.done === 1'b1) begin
            if (q2.size() == 0) begin
                chk("w2 unexpected done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("w2 d", 32'(if2.d), e.d);
                chk("w2 bout", 32'(if2.bout), 32'(e.bout));
                chk("w2 ovf", 32'(if2.ovf), 32'(e.ovf));
                chk("w2 done time", 32'($time), 32'(e.tdone));
            end
        end
    end

    // One 8-bit operation; returns at the negedge where done is expected.
    task automatic op8(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        if8.start = 1'b1; if8.a = a; if8.b = b;
        q8.push_back(model(8, 32'(a), 32'(b), $time));
        @(negedge clk);
        if8.start = 1'b0;
        chk("w8 busy", 32'(if8.busy), 32'd1);
        repeat (7) begin
            @(negedge clk);
            chk("w8 busy", 32'(if8.busy), 32'd1);
        end
        @(negedge clk);
        chk("w8 busy at done", 32'(if8.busy), 32'd0);
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b);
        @(negedge clk);
        if2.start = 1'b1; if2.a = a; if2.b = b;
        q2.push_back(model(2, 32'(a), 32'(b), $time));
        @(negedge clk);
        if2.start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        if8.start = 1'b0; if8.a = '0; if8.b = '0;
        if2.start = 1'b0; if2.a = '0; if2.b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst8 = 1'b0; rst2 = 1'b0;
        chk("rst busy", 32'(if8.busy), 32'd0);
        chk("rst done", 32'(if8.done), 32'd0);
        chk("rst d", 32'(if8.d), 32'd0);
        chk("rst bout", 32'(if8.bout), 32'd0);
        chk("rst ovf", 32'(if8.ovf), 32'd0);

        // Basic op and hold.
        op8(8'h35, 8'h12);
        repeat (20) begin
            @(negedge clk);
            chk("hold d", 32'(if8.d), 32'h23);
        end

        // Borrow / overflow corners.
        op8(8'h00, 8'h01);
        op8(8'h80, 8'h01);
        op8(8'h7F, 8'hFF);

        // Start during RUN is ignored, pin changes have no effect.
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h01;
        q8.push_back(model(8, 32'h10, 32'h01, $time));
        @(negedge clk);
        if8.start = 1'b0;
        repeat (2) @(negedge clk);
        if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF;
        @(negedge clk);
        if8.start = 1'b0; if8.a = 8'hAA; if8.b = 8'h33;
        repeat (10) @(negedge clk);

        // Reset mid-operation: discarded, no done.
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h55; if8.b = 8'h22;
        @(negedge clk);
        if8.start = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        chk("midrst busy", 32'(if8.busy), 32'd0);
        chk("midrst done", 32'(if8.done), 32'd0);
        chk("midrst d", 32'(if8.d), 32'd0);
        chk("midrst bout", 32'(if8.bout), 32'd0);
        chk("midrst ovf", 32'(if8.ovf), 32'd0);
        repeat (12) @(negedge clk);
        op8(8'h05, 8'h07);

        // Back-to-back with start held high.
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h09; if8.b = 8'h04;
        q8.push_back(model(8, 32'h09, 32'h04, $time));
        repeat (9) @(negedge clk);
        chk("b2b done", 32'(if8.done), 32'd1);
        if8.a = 8'h01; if8.b = 8'h02;
        q8.push_back(model(8, 32'h01, 32'h02, $time));
        @(negedge clk);
        if8.start = 1'b0;
        chk("b2b busy", 32'(if8.busy), 32'd1);
        repeat (8) @(negedge clk);

        // Random 8-bit ops with random idle gaps.
        repeat (12) begin
            op8(8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // WIDTH=2 exhaustive sweep.
        for (int i = 0; i < 16; i++) op2(2'(i >> 2), 2'(i));

        repeat (5) @(negedge clk);
        chk("w8 queue drained", 32'(q8.size()), 32'd0);
        chk("w2 queue drained", 32'(q2.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing d = a - b, LSB first, one bit per clock.
- Uses a one-bit full-subtractor cell with a registered borrow.
- Companion arithmetic block for the adder cells. Used where area matters more than latency.
- Simple start/busy/done handshake. Operands are captured on start; the result is registered and held until the next completion.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request to begin a subtraction; sampled only while busy=0
- a  input  WIDTH  minuend; sampled on the edge where start is accepted
- b  input  WIDTH  subtrahend; sampled on the edge where start is accepted
- busy  output  1  high while a subtraction is in progress
- done  output  1  single-cycle pulse; d, bout and ovf are valid from this cycle
- d  output  WIDTH  difference a - b, modulo 2^WIDTH
- bout  output  1  final borrow out; 1 iff unsigned a < unsigned b
- ovf  output  1  signed overflow flag

Behaviour:
- Reset: on a rising edge with rst=1, the FSM goes to IDLE.
  - busy=0, done=0, d=0, bout=0, ovf=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - rst has priority over every other input, including mid-operation: an in-flight subtraction is discarded and no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a and b into shift registers, clear borrow to 0, set counter=0, record a[WIDTH-1] and b[WIDTH-1], go to RUN.
  - start=0: stay in IDLE.
- RUN: at each edge, process bit i = counter.
  - Difference bit: a_i ^ b_i ^ bw.
  - Next borrow: (~a_i & b_i) | (~a_i & bw) | (b_i & bw).
  - Shift the difference bit into the MSB of the result shift register.
  - Shift the operand registers right by 1.
  - counter increments.
  - On the edge processing bit WIDTH-1: load d from the completed shift value, bout from the final borrow, ovf from (a_msb != b_msb) & (d[WIDTH-1] != a_msb). Go to DONE.
- DONE: done=1, busy=0 for exactly one cycle.
  - start=1 at this edge is accepted exactly as in IDLE, so back-to-back operation is possible; state goes to RUN.
  - Otherwise state goes to IDLE.
- busy = 1 iff state == RUN. done = 1 iff state == DONE. Both are decoded from registered state, so there are no combinational paths from inputs.
- Latency: start accepted at edge E0.
  - Bits are processed at edges E1..E(WIDTH).
  - done is high in the cycle following E(WIDTH).
  - Start-to-done is WIDTH+1 edges.
  - Throughput is one result per WIDTH+1 cycles with back-to-back starts.
- start while busy=1 is ignored. Changes on a and b during RUN have no effect.
- d, bout and ovf change only at the completing edge of an operation, or at reset. They hold their values through IDLE and through the whole of the next RUN.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
- WIDTH=8, reset, then start with a=0x35, b=0x12 -> busy high for 8 cycles, done pulse 9 edges after the start edge; d=0x23, bout=0, ovf=0. After done, d stays 0x23 for 20 idle cycles.
- a=0x00, b=0x01 -> d=0xFF, bout=1, ovf=0. Then a=0x80, b=0x01 -> d=0x7F, bout=0, ovf=1. Then a=0x7F, b=0xFF -> d=0x80, bout=1, ovf=1.
- Start with a=0x10, b=0x01. Pulse start again with a=0xFF, b=0xFF at cycle 3 of RUN, and change the a/b pins -> second start is ignored; d=0x0F, exactly one done pulse.
- Start with a=0x55, b=0x22, assert rst at cycle 4 of RUN -> next cycle busy=0, done=0, d=0, bout=0, ovf=0; no done pulse follows. A fresh start with a=0x05, b=0x07 gives d=0xFE, bout=1.
- Back-to-back: hold start=1 continuously with a=0x09, b=0x04, then switch operands in the done cycle to a=0x01, b=0x02 -> first done gives d=0x05; the second operation is accepted in that same done cycle and completes 9 edges later with d=0xFF, bout=1.
- WIDTH=2 sweep over all 16 (a,b) pairs -> d, bout and ovf match a reference model; done arrives 3 edges after each start.
